// File: rtl/cond_negate_pkg.sv
// rtl/cond_negate_pkg.sv - shared op encodings and width-limit helper for the conditional negator
package cond_negate_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;
  localparam logic [1:0] OP_NABS = 2'b11;

  // Widest operand the limit helper can describe; callers slice down to their width.
  localparam int LIM_W = 256;

  typedef struct packed {
    logic [LIM_W-1:0] max_pos;
    logic [LIM_W-1:0] max_neg;
  } limits_t;

  function automatic limits_t width_limits(input int w);
    limits_t l;
    l.max_pos = '0;
    l.max_neg = '0;
    for (int i = 0; i < LIM_W; i++) begin
      if (i < w - 1) l.max_pos[i] = 1'b1;
    end
    l.max_neg[w-1] = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/neg_slice.sv
// rtl/neg_slice.sv - conditional invert plus increment over one slice of the carry chain
module neg_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         cout
);

  logic [W:0] sum;

  assign sum       = {1'b0, (inv ? ~a : a)} + {{W{1'b0}}, cin};
  assign {cout, y} = sum;

endmodule

// File: rtl/cond_negate_pipe.sv
// rtl/cond_negate_pipe.sv - two-stage pass/neg/abs/nabs unit with overflow flag and valid/ready handshake
module cond_negate_pipe
  import cond_negate_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b0,
  localparam int LO_W = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int HI_W = WIDTH - LO_W;
  localparam limits_t LIM = width_limits(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = LIM.max_pos[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_NEG = LIM.max_neg[WIDTH-1:0];

  logic            s1_valid, s2_valid;
  logic            adv1, adv2;
  logic            inv;
  logic [LO_W-1:0] lo_y;
  logic            lo_cout;
  logic [LO_W-1:0] s1_lo;
  logic [HI_W-1:0] s1_hi;
  logic            s1_carry, s1_inv, s1_is_min;
  logic [HI_W-1:0] hi_y;
  logic            hi_cout_unused;
  logic [WIDTH-1:0] result;
  logic            ovf;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_comb begin
    inv = 1'b0;
    case (in_op)
      OP_PASS: inv = 1'b0;
      OP_NEG:  inv = 1'b1;
      OP_ABS:  inv = in_data[WIDTH-1];
      OP_NABS: inv = !in_data[WIDTH-1];
      default: inv = 1'b0;
    endcase
  end

  neg_slice #(.W(LO_W)) u_lo (
    .a    (in_data[LO_W-1:0]),
    .inv  (inv),
    .cin  (inv),
    .y    (lo_y),
    .cout (lo_cout)
  );

  neg_slice #(.W(HI_W)) u_hi (
    .a    (s1_hi),
    .inv  (s1_inv),
    .cin  (s1_carry),
    .y    (hi_y),
    .cout (hi_cout_unused)
  );

  // Only NEG/ABS of the most-negative value can leave the representable range.
  always_comb begin
    ovf    = s1_inv && s1_is_min;
    result = {hi_y, s1_lo};
    if (ovf && SAT) result = MAX_POS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        out_data <= result;
        out_ovf  <= ovf;
      end
    end
  end

  // Stage-1 data loads only on a real transfer so idle X on in_op/in_data never enters the pipe.
  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      s1_lo     <= lo_y;
      s1_carry  <= lo_cout;
      s1_hi     <= in_data[WIDTH-1:LO_W];
      s1_inv    <= inv;
      s1_is_min <= (in_data == MAX_NEG);
    end
  end

endmodule

// File: tb/tb_cond_negate_pipe.sv
// tb/tb_cond_negate_pipe.sv - directed checks of cond_negate_pipe at widths 8/32/64 with and without saturation
module tb_cond_negate_pipe;

  logic        clk, rst_n;
  logic        in_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] d32;
  logic [7:0]  d8;
  logic [63:0] d64;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [31:0] out_data_b;
  logic        in_ready_c, out_valid_c, out_ovf_c;
  logic [7:0]  out_data_c;
  logic        in_ready_d, out_valid_d, out_ovf_d;
  logic [63:0] out_data_d;

  int checks = 0;
  int errors = 0;

  cond_negate_pipe #(.WIDTH(32), .SAT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(d32), .in_op(in_op),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a));
  cond_negate_pipe #(.WIDTH(32), .SAT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(d32), .in_op(in_op),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_ovf(out_ovf_b));
  cond_negate_pipe #(.WIDTH(8), .SAT(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(d8), .in_op(in_op),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c), .out_ovf(out_ovf_c));
  cond_negate_pipe #(.WIDTH(64), .SAT(1'b0)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d), .in_data(d64), .in_op(in_op),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d), .out_ovf(out_ovf_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model32(input logic [1:0] op, input logic [31:0] x);
    logic [31:0] n;
    n = 32'd0 - x;
    case (op)
      2'b00:   return x;
      2'b01:   return n;
      2'b10:   return x[31] ? n : x;
      default: return x[31] ? x : n;
    endcase
  endfunction

  localparam int N1 = 17;
  logic [1:0]  op1  [N1];
  logic [31:0] din1 [N1];
  logic [31:0] ea1  [N1];
  logic        ov1  [N1];

  localparam int N2 = 4;
  logic [1:0]  op2  [N2];
  logic [7:0]  din8 [N2];
  logic [7:0]  e8   [N2];
  logic        ov8  [N2];
  logic [63:0] din64[N2];
  logic [63:0] e64  [N2];
  logic        ov64 [N2];

  logic [31:0] q[$];
  logic [1:0]  rop;
  logic [31:0] rdat;
  int sent, recv;

  initial begin
    op1  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11,
             2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10};
    din1 = '{32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h80000001, 32'h80000001, 32'h1234ABCD,
             32'h80000000, 32'h80000000, 32'h80000000, 32'h00010000, 32'h0000FFFF, 32'hFFFFFFFF,
             32'h00000000, 32'h00000000, 32'h00000001, 32'h00000007, 32'h0000000C};
    ea1  = '{32'hFFFFFFFB, 32'h00000000, 32'h00000001, 32'h7FFFFFFF, 32'h80000001, 32'h1234ABCD,
             32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFF0000, 32'hFFFF0001, 32'h00000001,
             32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h0000000C};
    ov1  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    op2   = '{2'b01, 2'b01, 2'b01, 2'b11};
    din8  = '{8'h80, 8'h10, 8'h0F, 8'h80};
    e8    = '{8'h7F, 8'hF0, 8'hF1, 8'h80};
    ov8   = '{1, 0, 0, 0};
    din64 = '{64'h8000000000000000, 64'h0000000100000000, 64'h00000000FFFFFFFF, 64'h8000000000000000};
    e64   = '{64'h8000000000000000, 64'hFFFFFFFF00000000, 64'hFFFFFFFF00000001, 64'h8000000000000000};
    ov64  = '{1, 0, 0, 0};

    // Reset with X on idle data/op inputs
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'bxx; d32 = 'x; d8 = 'x; d64 = 'x;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_ovf", out_ovf_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_out_valid", out_valid_a, 0);
      chk("idle_out_data", out_data_a, 0);
      chk("idle_out_ovf", out_ovf_a, 0);
      chk("idle_in_ready", in_ready_a, 1);
    end

    // Back-to-back directed vectors at 32 bits, SAT=0 and SAT=1 side by side
    d8 = '0; d64 = '0;
    for (int i = 0; i < N1 + 2; i++) begin
      @(negedge clk);
      chk("p1_in_ready", in_ready_a, 1);
      if (i >= 2) begin
        chk($sformatf("p1_valid[%0d]", i - 2), out_valid_a, 1);
        chk($sformatf("p1_data_a[%0d]", i - 2), out_data_a, ea1[i-2]);
        chk($sformatf("p1_ovf_a[%0d]", i - 2), out_ovf_a, ov1[i-2]);
        chk($sformatf("p1_data_b[%0d]", i - 2), out_data_b, ov1[i-2] ? 32'h7FFFFFFF : ea1[i-2]);
        chk($sformatf("p1_ovf_b[%0d]", i - 2), out_ovf_b, ov1[i-2]);
      end
      if (i < N1) begin
        in_valid = 1'b1; in_op = op1[i]; d32 = din1[i];
      end else begin
        in_valid = 1'b0; in_op = 2'bxx; d32 = 'x;
      end
    end
    @(negedge clk);
    chk("p1_drained", out_valid_a, 0);

    // Overflow and carry boundary at 8 (SAT=1) and 64 (SAT=0) bits
    d32 = '0;
    for (int i = 0; i < N2 + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("p2_valid8[%0d]", i - 2), out_valid_c, 1);
        chk($sformatf("p2_data8[%0d]", i - 2), out_data_c, e8[i-2]);
        chk($sformatf("p2_ovf8[%0d]", i - 2), out_ovf_c, ov8[i-2]);
        chk($sformatf("p2_valid64[%0d]", i - 2), out_valid_d, 1);
        chk($sformatf("p2_data64[%0d]", i - 2), out_data_d, e64[i-2]);
        chk($sformatf("p2_ovf64[%0d]", i - 2), out_ovf_d, ov64[i-2]);
      end
      if (i < N2) begin
        in_valid = 1'b1; in_op = op2[i]; d8 = din8[i]; d64 = din64[i];
      end else begin
        in_valid = 1'b0; in_op = 2'bxx;
      end
    end
    repeat (2) @(negedge clk);

    // Random valid/ready backpressure against the model, 8 beats
    sent = 0; recv = 0;
    rop = 2'($urandom_range(0, 3)); rdat = $urandom;
    for (int cyc = 0; cyc < 400 && recv < 8; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 8) && ($urandom_range(0, 1) == 1);
      in_op     = rop;
      d32       = rdat;
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      chk("bp_in_ready", in_ready_a, !(q.size() == 2 && !out_ready));
      if (q.size() == 0) chk("bp_spurious_valid", out_valid_a, 0);
      else if (out_valid_a) chk($sformatf("bp_data[%0d]", recv), out_data_a, q[0]);
      if (out_valid_a && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        recv++;
      end
      if (in_valid && in_ready_a) begin
        q.push_back(model32(rop, rdat));
        sent++;
        rop = 2'($urandom_range(0, 3)); rdat = $urandom;
      end
    end
    chk("bp_received", recv, 8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; in_op = 2'bxx;
    repeat (3) @(negedge clk);

    // Reset with two beats in flight
    in_valid = 1'b1; in_op = 2'b01; d32 = 32'd5;
    @(negedge clk);
    d32 = 32'd6;
    @(negedge clk);
    in_valid = 1'b0; in_op = 2'bxx;
    chk("mid_out_valid_pre", out_valid_a, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_out_data", out_data_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid_a, 0);
    end
    in_valid = 1'b1; in_op = 2'b01; d32 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0; in_op = 2'bxx;
    @(negedge clk);
    chk("post_rst_valid", out_valid_a, 1);
    chk("post_rst_data", out_data_a, 32'hFFFFFFFD);
    @(negedge clk);
    chk("post_rst_drained", out_valid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
